// File: rtl/ceres_pkg.sv
// Shared types for the ceres memory hierarchy: lower-level request/response
// structs and the enums used by the memory arbiter.
package ceres_pkg;

    localparam int XLEN     = 32;
    localparam int BLK_SIZE = 128;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [XLEN-1:0]     addr;
        logic [1:0]          rw_size;
        logic                rw;
        logic [BLK_SIZE-1:0] data;
        logic                uncached;
    } lowX_req_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [BLK_SIZE-1:0] data;
    } lowX_res_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_ICACHE = 1'b0,
        ARB_DCACHE = 1'b1
    } arb_port_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin 2:1 arbiter sharing the lower memory port between the icache
// (port 0) and dcache (port 1); one transaction outstanding at a time.
module mem_arbiter #(
    parameter type lowX_req_t = ceres_pkg::lowX_req_t,
    parameter type lowX_res_t = ceres_pkg::lowX_res_t,
    parameter int  BLK_SIZE   = ceres_pkg::BLK_SIZE,
    parameter int  XLEN       = ceres_pkg::XLEN
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  lowX_req_t icache_req_i,
    output lowX_res_t icache_res_o,
    input  lowX_req_t dcache_req_i,
    output lowX_res_t dcache_res_o,
    output lowX_req_t mem_req_o,
    input  lowX_res_t mem_res_i,
    output logic      busy_o
);
    import ceres_pkg::*;

    arb_state_e          state;
    arb_state_e          state_next;
    arb_port_e           last_grant;
    arb_port_e           grant_q;
    arb_port_e           winner;
    logic                grant_en;
    lowX_req_t           win_req;
    lowX_res_t           owner_res;
    logic [BLK_SIZE-1:0] mem_data;

    logic [XLEN-1:0]     addr_q;
    logic [BLK_SIZE-1:0] data_q;
    logic [1:0]          rw_size_q;
    logic                rw_q;
    logic                uncached_q;
    logic                ready_q;

    assign mem_data = mem_res_i.data;

    // On a tie the port that did not win last time is served.
    always_comb begin
        winner = ARB_ICACHE;
        if (icache_req_i.valid && dcache_req_i.valid) begin
            winner = (last_grant == ARB_ICACHE) ? ARB_DCACHE : ARB_ICACHE;
        end else if (dcache_req_i.valid) begin
            winner = ARB_DCACHE;
        end
    end

    assign win_req = (winner == ARB_DCACHE) ? dcache_req_i : icache_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= ARB_ICACHE;
        end else begin
            state <= state_next;
            if (grant_en) begin
                last_grant <= winner;
            end
        end
    end

    // Granted request copy; only observed outside IDLE, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (grant_en) begin
            grant_q    <= winner;
            addr_q     <= win_req.addr;
            data_q     <= win_req.data;
            rw_size_q  <= win_req.rw_size;
            rw_q       <= win_req.rw;
            uncached_q <= win_req.uncached;
            ready_q    <= win_req.ready;
        end
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        busy_o     = (state != IDLE);
        mem_req_o  = '0;
        owner_res  = '0;
        case (state)
            IDLE: begin
                if (icache_req_i.valid || dcache_req_i.valid) begin
                    grant_en   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req_o.valid    = 1'b1;
                mem_req_o.ready    = ready_q;
                mem_req_o.addr     = addr_q;
                mem_req_o.rw_size  = rw_size_q;
                mem_req_o.rw       = rw_q;
                mem_req_o.data     = data_q;
                mem_req_o.uncached = uncached_q;
                if (mem_res_i.ready) begin
                    owner_res.ready = 1'b1;
                    if (mem_res_i.valid) begin
                        owner_res.valid = 1'b1;
                        owner_res.data  = mem_data;
                        state_next      = IDLE;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (mem_res_i.valid) begin
                    owner_res.valid = 1'b1;
                    owner_res.data  = mem_data;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // owner_res is already '0 in IDLE, so stale grant_q never leaks a response.
    assign icache_res_o = (grant_q == ARB_ICACHE) ? owner_res : '0;
    assign dcache_res_o = (grant_q == ARB_DCACHE) ? owner_res : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level model.
module tb_mem_arbiter;
    import ceres_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic      rst_i;
    lowX_req_t icache_req;
    lowX_res_t icache_res;
    lowX_req_t dcache_req;
    lowX_res_t dcache_res;
    lowX_req_t mem_req;
    lowX_res_t mem_res;
    logic      busy;

    mem_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .icache_req_i (icache_req),
        .icache_res_o (icache_res),
        .dcache_req_i (dcache_req),
        .dcache_res_o (dcache_res),
        .mem_req_o    (mem_req),
        .mem_res_i    (mem_res),
        .busy_o       (busy)
    );

    localparam logic [BLK_SIZE-1:0] DATA_A = {4{32'hAAAA_AAAA}};
    localparam logic [BLK_SIZE-1:0] DATA_B = {4{32'hBBBB_BBBB}};
    localparam logic [BLK_SIZE-1:0] DATA_DB = {64'h0, 64'hDEAD_BEEF_DEAD_BEEF};

    int n_checks = 0;
    int n_errors = 0;

    // Transaction model: one open transaction with an owner, accepted or not.
    bit        m_open;
    bit        m_acc;
    int        m_owner;
    int        m_last;
    lowX_req_t m_req;
    lowX_res_t exp_ires;
    lowX_res_t exp_dres;
    bit        prev_mv;
    int        grant_log[$];
    logic [BLK_SIZE-1:0] last_data [2];

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic lowX_req_t mk_req(input logic [XLEN-1:0] addr, input logic rw,
                                         input logic [1:0] rw_size, input logic uncached,
                                         input logic [BLK_SIZE-1:0] data);
        lowX_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.addr     = addr;
        r.rw       = rw;
        r.rw_size  = rw_size;
        r.uncached = uncached;
        r.data     = data;
        return r;
    endfunction

    function automatic lowX_req_t rand_req();
        return mk_req($urandom, 1'($urandom), 2'($urandom), 1'($urandom),
                      {$urandom, $urandom, $urandom, $urandom});
    endfunction

    // Inputs are set by the caller just after a falling edge.
    task automatic step();
        lowX_req_t exp_mreq;
        lowX_res_t r;
        #1;
        exp_mreq = '0;
        r        = '0;
        if (m_open && !m_acc) begin
            exp_mreq       = m_req;
            exp_mreq.valid = 1'b1;
        end
        if (m_open) begin
            if (!m_acc) begin
                if (mem_res.ready) begin
                    r.ready = 1'b1;
                    if (mem_res.valid) begin
                        r.valid = 1'b1;
                        r.data  = mem_res.data;
                    end
                end
            end else if (mem_res.valid) begin
                r.valid = 1'b1;
                r.data  = mem_res.data;
            end
        end
        exp_ires = (m_open && m_owner == 0) ? r : '0;
        exp_dres = (m_open && m_owner == 1) ? r : '0;

        check("busy",       200'(busy),       200'(m_open));
        check("mem_req",    200'(mem_req),    200'(exp_mreq));
        check("icache_res", 200'(icache_res), 200'(exp_ires));
        check("dcache_res", 200'(dcache_res), 200'(exp_dres));

        if (mem_req.valid && !prev_mv) grant_log.push_back((mem_req.addr == 32'h2000_0000) ? 1 : 0);
        prev_mv = mem_req.valid;
        if (icache_res.valid) last_data[0] = icache_res.data;
        if (dcache_res.valid) last_data[1] = dcache_res.data;

        if (rst_i) begin
            m_open = 1'b0;
            m_acc  = 1'b0;
            m_last = 0;
        end else if (!m_open) begin
            if (icache_req.valid || dcache_req.valid) begin
                if (icache_req.valid && dcache_req.valid) m_owner = 1 - m_last;
                else m_owner = dcache_req.valid ? 1 : 0;
                m_last = m_owner;
                m_req  = (m_owner == 1) ? dcache_req : icache_req;
                m_open = 1'b1;
                m_acc  = 1'b0;
            end
        end else if (!m_acc) begin
            if (mem_res.ready) begin
                if (mem_res.valid) m_open = 1'b0;
                else m_acc = 1'b1;
            end
        end else if (mem_res.valid) begin
            m_open = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        icache_req = '0;
        dcache_req = '0;
        mem_res    = '0;
        rst_i      = 1'b1;
        step();
        rst_i = 1'b0;
        step();
    endtask

    initial begin
        rst_i      = 1'b1;
        icache_req = '0;
        dcache_req = '0;
        mem_res    = '0;
        m_open     = 1'b0;
        m_acc      = 1'b0;
        m_owner    = 0;
        m_last     = 0;
        m_req      = '0;
        prev_mv    = 1'b0;
        last_data[0] = '0;
        last_data[1] = '0;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Single icache read with separate accept and data
        icache_req = mk_req(32'h0000_0040, 1'b0, 2'b11, 1'b0, '0);
        step();
        step();
        mem_res.ready = 1'b1;
        step();
        icache_req = '0;
        mem_res    = '0;
        step();
        mem_res.valid = 1'b1;
        mem_res.data  = DATA_DB;
        step();
        mem_res = '0;
        step();
        check("t1_icache_data", 200'(last_data[0]), 200'(DATA_DB));

        // Simultaneous requests from reset, then continuous contention
        do_reset();
        grant_log.delete();
        icache_req = mk_req(32'h1000_0000, 1'b0, 2'b11, 1'b0, '0);
        dcache_req = mk_req(32'h2000_0000, 1'b0, 2'b11, 1'b0, '0);
        for (int c = 0; c < 12; c++) begin
            mem_res = '0;
            if (mem_req.valid) begin
                mem_res.ready = 1'b1;
                mem_res.valid = 1'b1;
                mem_res.data  = (mem_req.addr == 32'h1000_0000) ? DATA_A : DATA_B;
            end
            step();
        end
        icache_req = '0;
        dcache_req = '0;
        mem_res    = '0;
        step();
        check("grant_count", 200'(grant_log.size()), 200'(6));
        for (int k = 0; k < grant_log.size() && k < 6; k++)
            check($sformatf("grant_%0d", k), 200'(grant_log[k]), 200'((k % 2 == 0) ? 1 : 0));
        check("icache_own_data", 200'(last_data[0]), 200'(DATA_A));
        check("dcache_own_data", 200'(last_data[1]), 200'(DATA_B));

        // Reset while waiting for data: late response must be dropped
        do_reset();
        last_data[0] = '0;
        last_data[1] = '0;
        icache_req = mk_req(32'h3000_0000, 1'b0, 2'b11, 1'b0, '0);
        step();
        mem_res.ready = 1'b1;
        step();
        icache_req = '0;
        mem_res    = '0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        mem_res.valid = 1'b1;
        mem_res.data  = BLK_SIZE'(16'h1234);
        step();
        mem_res = '0;
        step();
        check("rst_icache_data", 200'(last_data[0]), 200'(0));
        check("rst_dcache_data", 200'(last_data[1]), 200'(0));

        // Uncached dcache write
        dcache_req = mk_req(32'h2000_0000, 1'b1, 2'b10, 1'b1, {4{32'h5A5A_0F0F}});
        step();
        mem_res.ready = 1'b1;
        step();
        dcache_req = '0;
        mem_res    = '0;
        step();
        mem_res.valid = 1'b1;
        mem_res.data  = DATA_B;
        step();
        mem_res = '0;
        step();

        // Requester drops valid after its grant; transaction still completes
        icache_req = mk_req(32'h0000_0080, 1'b0, 2'b11, 1'b0, '0);
        step();
        icache_req = '0;
        step();
        mem_res.ready = 1'b1;
        mem_res.valid = 1'b1;
        mem_res.data  = DATA_A;
        step();
        mem_res = '0;
        step();

        // Randomized traffic, including stray memory handshakes and resets
        for (int c = 0; c < 1500; c++) begin
            if (exp_ires.ready) icache_req = '0;
            if (exp_dres.ready) dcache_req = '0;
            if (m_open && !m_acc && ($urandom % 16 == 0)) begin
                if (m_owner == 0) icache_req = '0;
                else dcache_req = '0;
            end
            if (!icache_req.valid && ($urandom % 3 == 0)) icache_req = rand_req();
            if (!dcache_req.valid && ($urandom % 3 == 0)) dcache_req = rand_req();
            mem_res.ready = 1'($urandom % 2);
            mem_res.valid = ($urandom % 3 == 0);
            mem_res.data  = {$urandom, $urandom, $urandom, $urandom};
            rst_i = ($urandom % 64 == 0);
            step();
        end
        rst_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
